// File: rtl/ln_fixed_scaler.sv
// Fixed-point natural log stage: Mitchell log2 estimate scaled by ln2 with an
// 8-cycle shift-add multiply. One transaction in flight, valid/ready on both sides.
module ln_fixed_scaler #(
  parameter int unsigned LN2_Q   = 177,
  parameter int unsigned CONST_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  v_in,
  input  logic [7:0]  exp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] ln_out,
  output logic        err
);

  localparam int unsigned A_W   = 10;
  localparam int unsigned ACC_W = 18;
  localparam int unsigned OUT_W = 11;
  localparam int unsigned CNT_W = (CONST_W > 1) ? $clog2(CONST_W) : 1;
  localparam logic [CONST_W-1:0] LN2_BITS = CONST_W'(LN2_Q);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CONST_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [A_W-1:0]     a_reg;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic               in_err_c;
  logic [7:0]         mant_c;
  logic [A_W-1:0]     a_c;
  logic [ACC_W-1:0]   acc_add_c;
  logic [ACC_W-1:0]   acc_next_c;

  // Input pair is consistent only when v_in lies in [2^e, 2^(e+1)-1], i.e. v_in >> e == 1
  always_comb begin
    in_err_c = (exp_in > 8'd7) || ((v_in >> exp_in[2:0]) != 8'd1);
    mant_c   = v_in << (3'd7 - exp_in[2:0]);
    a_c      = {exp_in[2:0], mant_c[6:0]};
  end

  // One partial product per multiplier bit; acc width covers 1023 * 177 without overflow
  always_comb begin
    acc_add_c  = LN2_BITS[cnt] ? (ACC_W'(a_reg) << cnt) : '0;
    acc_next_c = acc + acc_add_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ln_out    <= '0;
      err       <= 1'b0;
      a_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            if (in_err_c) begin
              state     <= DONE;
              out_valid <= 1'b1;
              ln_out    <= '0;
              err       <= 1'b1;
            end else begin
              state <= MUL;
              a_reg <= a_c;
              err   <= 1'b0;
            end
          end
        end
        MUL: begin
          acc <= acc_next_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ln_out    <= acc_next_c[ACC_W-1 -: OUT_W];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ln_fixed_scaler.sv
// Randomized bench for ln_fixed_scaler against an arithmetic Mitchell/ln2 model.
module tb_ln_fixed_scaler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  v_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] ln_out;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ln_fixed_scaler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v_in      (v_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ln_out    (ln_out),
    .err       (err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_err(input int v, input int e);
    if (v == 0 || e > 7) return 1;
    return ((v < (1 << e)) || (v >= (1 << (e + 1)))) ? 1 : 0;
  endfunction

  // log2(v) ~ e + (v - 2^e)/2^e in Q3.7, times ln2 (177/256), truncated to Q3.8
  function automatic int model_ln(input int v, input int e);
    int a;
    a = e * 128 + ((v - (1 << e)) * 128) / (1 << e);
    return (a * 177) / 128;
  endfunction

  task automatic txn(input int v, input int e, input int stall, input bit junk);
    int exp_err;
    int exp_ln;
    int guard;
    int lat;
    real t;
    real got;
    exp_err = model_err(v, e);
    exp_ln  = exp_err ? 0 : model_ln(v, e);
    v_in     = 8'(v);
    exp_in   = 8'(e);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_timeout", (guard < 50) ? 1 : 0, 1);
    tick();
    if (junk) begin
      v_in   = 8'($urandom);
      exp_in = 8'($urandom_range(0, 9));
    end else begin
      in_valid = 1'b0;
    end
    check("in_ready_busy", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      check("no_overlap", int'(in_ready & out_valid), 0);
      lat++;
    end
    check("latency", lat, exp_err ? 0 : 8);
    check("err", int'(err), exp_err);
    check("ln_out", int'(ln_out), exp_ln);
    check("in_ready_done", int'(in_ready), 0);
    if (!exp_err) begin
      t   = $ln(real'(v)) * 256.0;
      got = real'(ln_out);
      check("ln_bound", (got <= t && (t - got) < 23.04) ? 1 : 0, 1);
    end
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_ln", int'(ln_out), exp_ln);
      check("hold_err", int'(err), exp_err);
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("release_valid", int'(out_valid), 0);
    check("release_ready", int'(in_ready), 1);
  endtask

  initial begin
    int e;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    v_in      = '0;
    exp_in    = '0;
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_ln_out", int'(ln_out), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    tick();

    txn(1, 0, 0, 1'b0);
    txn(2, 1, 0, 1'b0);
    txn(10, 3, 1, 1'b0);
    txn(255, 7, 0, 1'b0);
    txn(0, 0, 0, 1'b0);
    txn(10, 2, 2, 1'b0);
    txn(5, 9, 0, 1'b0);
    txn(2, 1, 5, 1'b1);

    // Abort a multiply with reset; nothing may come out afterwards
    v_in     = 8'd10;
    exp_in   = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("abort_no_output", seen, 0);

    for (int v = 1; v < 256; v++) begin
      e = 0;
      while ((v >> (e + 1)) != 0) e++;
      txn(v, e, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 30; i++) begin
      txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 10)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
